uart_rx_pkt_ctrl: RTL and testbench
===================================

# uart_rx_pkt_ctrl

Packet-level controller that sits directly behind the UART byte receiver and sequences its output stream into register-write transactions. It hunts for a sync byte, frames a fixed-format packet (address, length, payload, XOR checksum), and buffers the payload internally. Only after the checksum passes does it replay the payload as back-to-back register writes to the downstream register file. Malformed, corrupted or stalled packets are discarded with an error pulse and code, so no partial writes ever occur.

## Interface
- SYNC_BYTE, 8'hA5: packet start marker.
- MAX_LEN, 16: maximum payload bytes (1..255); sets buffer depth.
- TIMEOUT_CLKS, 50000: max clk_50M cycles allowed between bytes inside a packet (1 ms at 50 MHz).

Ports:
- clk_50M  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- i_data_byte  in  8  received byte; valid only when i_data_avail=1.
- i_data_avail  in  1  single-cycle byte strobe from the receiver.
- o_wr_en  out  1  register write strobe, one cycle per byte.
- o_wr_addr  out  8  write address, valid with o_wr_en.
- o_wr_data  out  8  write data, valid with o_wr_en.
- o_pkt_done  out  1  one-cycle pulse: packet committed.
- o_pkt_err  out  1  one-cycle pulse: packet discarded.
- o_err_code  out  2  last error (0 none, 1 bad length, 2 checksum, 3 timeout); holds until next error or reset.
- o_busy  out  1  high in every state except IDLE.

## Operation
- Packet format: SYNC_BYTE, ADDR, LEN, LEN payload bytes, CHK.
- CHK must equal ADDR ^ LEN ^ payload[0] ^ … ^ payload[LEN-1].
- FSM states: IDLE, ADDR, LEN, DATA, CHK, WRITE.
- IDLE: a byte equal to SYNC_BYTE moves the FSM to ADDR. Any other byte is dropped silently, with no error.
- ADDR: the byte is latched as the base address and seeds the running XOR. Next state LEN.
- LEN: a value of 0 or greater than MAX_LEN raises error 1 and returns to IDLE. Otherwise LEN is latched, the payload index is cleared, and the FSM moves to DATA.
- DATA: each byte is written to buf[index], index increments, and the byte is XORed into the running checksum. The FSM moves to CHK after byte LEN-1.
- CHK: a match with the running XOR moves the FSM to WRITE. A mismatch raises error 2 and returns to IDLE with no writes.
- WRITE: issues one write per cycle for k = 0..LEN-1, with o_wr_addr = (ADDR + k) mod 256 (8-bit wrap) and o_wr_data = buf[k]. Returns to IDLE afterwards.
- Bytes arriving during WRITE are dropped. WRITE lasts at most 255 cycles, far shorter than any UART byte time.
- Timeout: a counter clears on every i_data_avail and on entry to ADDR. It increments while the FSM is in ADDR, LEN, DATA or CHK. At TIMEOUT_CLKS-1 it raises error 3 and the FSM returns to IDLE.
- Byte strobe and timeout in the same cycle: the byte wins and the counter clears.
- A SYNC_BYTE value received mid-packet is treated as ordinary data; there is no resync.
- Reset at any point, including mid-WRITE: the FSM goes to IDLE and all outputs go to 0. Remaining writes are abandoned, and no done or error pulse is issued.

## Timing
- All outputs are registered. Reset value is 0 for o_wr_en, o_wr_addr, o_wr_data, o_pkt_done, o_pkt_err, o_err_code and o_busy.
- Let cycle T be the cycle in which the CHK byte's i_data_avail is sampled high.
  - On a checksum match, o_wr_en is high in cycles T+1 … T+LEN.
  - o_pkt_done pulses in cycle T+LEN, together with the last write.
  - The FSM is in IDLE and accepting bytes at T+LEN+1.
- Error on the byte sampled at T: o_pkt_err and the new o_err_code appear at T+1. The FSM is in IDLE at T+1.
- Timeout: o_pkt_err pulses in the cycle after the counter reaches TIMEOUT_CLKS-1.
- o_busy rises the cycle after SYNC_BYTE is accepted. It falls the cycle after the last write or after the error.
- o_wr_addr and o_wr_data hold their last values when o_wr_en=0.

## Test plan
- Good packet A5 10 02 11 22 21:
  - writes (0x10,0x11) at T+1 and (0x11,0x22) at T+2;
  - o_pkt_done at T+2; o_err_code stays 0.
- Address wrap A5 FF 02 AA BB EC: writes (0xFF,0xAA) then (0x00,0xBB), then o_pkt_done.
- Bad checksum A5 10 02 11 22 20: no o_wr_en; o_pkt_err pulse; o_err_code=2. A following good packet commits normally.
- Length errors:
  - A5 10 00: error 1, no writes.
  - A5 10 11 with MAX_LEN=16: error 1.
  - A5 10 10 plus 16 payload bytes plus correct CHK: 16 writes.
- Timeout: A5 10 then silence. o_pkt_err with code 3 occurs exactly TIMEOUT_CLKS cycles after the 0x10 strobe.
  - Repeat with a strobe landing on the timeout cycle: no error.
- Noise and reset:
  - Bytes 00 FF 5A in IDLE produce no pulses and o_busy=0.
  - rst asserted during WRITE of a 4-byte packet: o_wr_en=0 the next cycle, no o_pkt_done, and all outputs are 0.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames SYNC/ADDR/LEN/payload/CHK packets from the UART byte stream and replays verified payloads as register writes.
// All outputs registered (first write the cycle after the CHK strobe); no backpressure, so bytes arriving during WRITE are dropped.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [7:0] i_data_byte,
  input  logic       i_data_avail,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_pkt_done,
  output logic       o_pkt_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);
  localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_WRITE} state_t;
  state_t state, nxt_state;

  logic [7:0]    base_addr, pkt_len, idx, chk_acc;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    buf_mem [MAX_LEN];

  logic       counting, tmo_hit, len_bad, chk_ok, last_byte;
  logic [7:0] wr_k;
  logic       wr_en_d, done_d, err_d;
  logic [1:0] err_code_d;
  logic [7:0] wr_addr_d, wr_data_d;

  assign counting  = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign tmo_hit   = counting && !i_data_avail && (tmo_cnt == TMO_LAST);
  assign len_bad   = (i_data_byte == 8'd0) || (i_data_byte > MAX_LEN_B);
  assign chk_ok    = (i_data_byte == chk_acc);
  assign last_byte = (idx == pkt_len - 8'd1);
  // The first write is launched from CHK; later ones walk idx through WRITE.
  assign wr_k      = (state == S_WRITE) ? idx : 8'd0;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state      <= S_IDLE;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= 8'd0;
      o_wr_data  <= 8'd0;
      o_pkt_done <= 1'b0;
      o_pkt_err  <= 1'b0;
      o_err_code <= 2'd0;
      o_busy     <= 1'b0;
    end else begin
      state      <= nxt_state;
      o_wr_en    <= wr_en_d;
      o_wr_addr  <= wr_addr_d;
      o_wr_data  <= wr_data_d;
      o_pkt_done <= done_d;
      o_pkt_err  <= err_d;
      o_err_code <= err_code_d;
      o_busy     <= (nxt_state != S_IDLE);
    end
  end

  always_comb begin
    nxt_state = state;
    if (tmo_hit) begin
      nxt_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_data_avail && i_data_byte == SYNC_BYTE) nxt_state = S_ADDR;
        S_ADDR:  if (i_data_avail) nxt_state = S_LEN;
        S_LEN:   if (i_data_avail) nxt_state = len_bad ? S_IDLE : S_DATA;
        S_DATA:  if (i_data_avail && last_byte) nxt_state = S_CHK;
        S_CHK:   if (i_data_avail) nxt_state = chk_ok ? S_WRITE : S_IDLE;
        S_WRITE: if (idx == pkt_len) nxt_state = S_IDLE;
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en_d    = 1'b0;
    wr_addr_d  = o_wr_addr;
    wr_data_d  = o_wr_data;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = o_err_code;
    if (tmo_hit) begin
      err_d      = 1'b1;
      err_code_d = 2'd3;
    end else if ((state == S_LEN) && i_data_avail && len_bad) begin
      err_d      = 1'b1;
      err_code_d = 2'd1;
    end else if ((state == S_CHK) && i_data_avail && !chk_ok) begin
      err_d      = 1'b1;
      err_code_d = 2'd2;
    end else if (((state == S_CHK) && i_data_avail) || ((state == S_WRITE) && (idx != pkt_len))) begin
      wr_en_d   = 1'b1;
      wr_addr_d = base_addr + wr_k;
      wr_data_d = buf_mem[wr_k[IW-1:0]];
      done_d    = (wr_k == pkt_len - 8'd1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      base_addr <= 8'd0;
      pkt_len   <= 8'd0;
      idx       <= 8'd0;
      chk_acc   <= 8'd0;
      tmo_cnt   <= '0;
    end else begin
      // Counts cycles since the last strobe, so a strobe cycle itself is count zero.
      if (i_data_avail)  tmo_cnt <= TW'(1);
      else if (counting) tmo_cnt <= tmo_cnt + TW'(1);
      else               tmo_cnt <= '0;
      case (state)
        S_ADDR: if (i_data_avail) begin
          base_addr <= i_data_byte;
          chk_acc   <= i_data_byte;
        end
        S_LEN: if (i_data_avail) begin
          pkt_len <= i_data_byte;
          chk_acc <= chk_acc ^ i_data_byte;
          idx     <= 8'd0;
        end
        S_DATA: if (i_data_avail) begin
          idx     <= idx + 8'd1;
          chk_acc <= chk_acc ^ i_data_byte;
        end
        S_CHK:   if (i_data_avail) idx <= 8'd1;
        S_WRITE: idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if ((state == S_DATA) && i_data_avail) buf_mem[idx[IW-1:0]] <= i_data_byte;
  end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: framing, commit timing, error codes, timeout and reset abandonment.
module tb_uart_rx_pkt_ctrl;
  localparam int TO = 40;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data_byte = 8'd0;
  logic       i_data_avail = 1'b0;
  logic       o_wr_en, o_pkt_done, o_pkt_err, o_busy;
  logic [7:0] o_wr_addr, o_wr_data;
  logic [1:0] o_err_code;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int wr_base, done_base, err_base;
  logic [7:0] payload [16];
  logic [7:0] chk16;

  uart_rx_pkt_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(TO)) dut (
    .clk_50M(clk_50M), .rst(rst), .i_data_byte(i_data_byte), .i_data_avail(i_data_avail),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_pkt_done(o_pkt_done),
    .o_pkt_err(o_pkt_err), .o_err_code(o_err_code), .o_busy(o_busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (o_wr_en)    wr_cnt++;
    if (o_pkt_done) done_cnt++;
    if (o_pkt_err)  err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  // Strobe one byte; returns one cycle after the strobe was sampled.
  task automatic send_byte(input logic [7:0] b);
    i_data_byte  = b;
    i_data_avail = 1'b1;
    tick();
    i_data_avail = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    tick();
  endtask

  task automatic snap();
    wr_base   = wr_cnt;
    done_base = done_cnt;
    err_base  = err_cnt;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done, o_pkt_err, o_err_code, o_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Good packet A5 10 02 11 22 21
    snap();
    send_byte(8'hA5);
    check("busy_after_sync", o_busy, 1);
    tick();
    send_gap(8'h10); send_gap(8'h02); send_gap(8'h11); send_gap(8'h22);
    check("no_wr_before_chk", wr_cnt - wr_base, 0);
    send_byte(8'h21);
    check("good_w0", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done}, {1'b1, 8'h10, 8'h11, 1'b0});
    tick();
    check("good_w1", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done, o_busy}, {1'b1, 8'h11, 8'h22, 1'b1, 1'b1});
    tick();
    check("good_after", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done, o_busy, o_err_code}, {1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 2'd0});
    check("good_counts", {wr_cnt - wr_base, done_cnt - done_base, err_cnt - err_base}, {32'd2, 32'd1, 32'd0});

    // Address wrap A5 FF 02 AA BB EC
    send_gap(8'hA5); send_gap(8'hFF); send_gap(8'h02); send_gap(8'hAA); send_gap(8'hBB);
    send_byte(8'hEC);
    check("wrap_w0", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done}, {1'b1, 8'hFF, 8'hAA, 1'b0});
    tick();
    check("wrap_w1", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done}, {1'b1, 8'h00, 8'hBB, 1'b1});
    tick();

    // Bad checksum, then a good packet still commits
    snap();
    send_gap(8'hA5); send_gap(8'h10); send_gap(8'h02); send_gap(8'h11); send_gap(8'h22);
    send_byte(8'h20);
    check("badchk_err", {o_wr_en, o_pkt_err, o_err_code, o_busy}, {1'b0, 1'b1, 2'd2, 1'b0});
    tick();
    check("badchk_hold", {o_pkt_err, o_err_code}, {1'b0, 2'd2});
    check("badchk_nowr", wr_cnt - wr_base, 0);
    send_gap(8'hA5); send_gap(8'h10); send_gap(8'h02); send_gap(8'h11); send_gap(8'h22);
    send_byte(8'h21);
    check("recover_w0", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 8'h10, 8'h11});
    tick();
    check("recover_w1", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done, o_err_code}, {1'b1, 8'h11, 8'h22, 1'b1, 2'd2});
    tick();

    // Length errors
    snap();
    send_gap(8'hA5); send_gap(8'h10);
    send_byte(8'h11);
    check("len17_err", {o_pkt_err, o_err_code, o_busy}, {1'b1, 2'd1, 1'b0});
    tick();
    send_gap(8'hA5); send_gap(8'h10);
    send_byte(8'h00);
    check("len0_err", {o_pkt_err, o_err_code, o_busy}, {1'b1, 2'd1, 1'b0});
    tick(); tick();
    check("len_err_counts", {wr_cnt - wr_base, err_cnt - err_base}, {32'd0, 32'd2});

    // Maximum length packet (16 bytes)
    chk16 = 8'h10 ^ 8'h10;
    for (int k = 0; k < 16; k++) begin
      payload[k] = 8'(k * 7 + 3);
      chk16 = chk16 ^ payload[k];
    end
    snap();
    send_gap(8'hA5); send_gap(8'h10); send_gap(8'h10);
    for (int k = 0; k < 16; k++) send_gap(payload[k]);
    send_byte(chk16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("max_w%0d", k), {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done},
            {1'b1, 8'(8'h10 + k), payload[k], (k == 15)});
      tick();
    end
    check("max_after", {o_wr_en, o_busy}, 2'b00);
    check("max_counts", {wr_cnt - wr_base, done_cnt - done_base}, {32'd16, 32'd1});

    // Timeout: error exactly TO cycles after the ADDR strobe
    send_gap(8'hA5);
    send_byte(8'h10);
    repeat (TO - 2) tick();
    check("tmo_before", {o_pkt_err, o_busy}, 2'b01);
    tick();
    check("tmo_err", {o_pkt_err, o_err_code, o_busy}, {1'b1, 2'd3, 1'b0});
    tick();
    check("tmo_pulse_end", o_pkt_err, 0);

    // Strobe on the timeout cycle wins; finish as a 1-byte packet
    snap();
    send_gap(8'hA5);
    send_byte(8'h10);
    repeat (TO - 2) tick();
    send_byte(8'h01);
    check("tmo_byte_wins", {o_pkt_err, o_busy}, 2'b01);
    tick();
    send_gap(8'h5C);
    send_byte(8'h4D);
    check("len1_w0", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done}, {1'b1, 8'h10, 8'h5C, 1'b1});
    tick();
    check("len1_idle", {o_wr_en, o_busy, o_err_code}, {1'b0, 1'b0, 2'd3});
    check("tmo_byte_noerr", err_cnt - err_base, 0);

    // Noise in IDLE
    snap();
    send_byte(8'h00); check("noise_00_busy", o_busy, 0); tick();
    send_byte(8'hFF); check("noise_ff_busy", o_busy, 0); tick();
    send_byte(8'h5A); check("noise_5a_busy", o_busy, 0); tick(); tick();
    check("noise_counts", {wr_cnt - wr_base, done_cnt - done_base, err_cnt - err_base}, 96'd0);

    // Reset in the middle of a 4-byte WRITE burst
    snap();
    send_gap(8'hA5); send_gap(8'h20); send_gap(8'h04);
    send_gap(8'h01); send_gap(8'h02); send_gap(8'h03); send_gap(8'h04);
    send_byte(8'h20);
    check("rstw_w0", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 8'h20, 8'h01});
    tick();
    check("rstw_w1", {o_wr_en, o_wr_addr, o_wr_data}, {1'b1, 8'h21, 8'h02});
    rst = 1'b1;
    tick();
    check("rstw_zero", {o_wr_en, o_wr_addr, o_wr_data, o_pkt_done, o_pkt_err, o_err_code, o_busy}, 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("rstw_stays_idle", {o_wr_en, o_busy}, 2'b00);
    check("rstw_counts", {wr_cnt - wr_base, done_cnt - done_base, err_cnt - err_base}, {32'd2, 32'd0, 32'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
